mips_multicycle_ctrl_fsm: RTL

- Multicycle MIPS main controller; sits directly upstream of the ALU decoder and drives its 3-bit ALUOp input.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Produces all datapath enables and mux selects.
- Waits on a memory-ready handshake during memory phases.

---
 rtl/mips_multicycle_ctrl_fsm.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_fsm
// Brief    : Multicycle MIPS main controller FSM driving datapath enables/selects.
// Revision : 1.0
// ============================================================================
module mips_multicycle_ctrl_fsm #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [3:0] state
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMRD    = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWR    = 4'd5;
    localparam logic [3:0] S_RTYPE_EX = 4'd6;
    localparam logic [3:0] S_RTYPE_WB = 4'd7;
    localparam logic [3:0] S_BEQ_EX   = 4'd8;
    localparam logic [3:0] S_ADDI_EX  = 4'd9;
    localparam logic [3:0] S_IMM_WB   = 4'd10;
    localparam logic [3:0] S_J_EX     = 4'd11;
    localparam logic [3:0] S_ANDI_EX  = 4'd12;
    localparam logic [3:0] S_ORI_EX   = 4'd13;
    localparam logic [3:0] S_HALT     = 4'd15;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    logic [3:0] state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_ANDI:      state_d = S_ANDI_EX;
                    OP_ORI:       state_d = S_ORI_EX;
                    OP_J:         state_d = S_J_EX;
                    default:      state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:    state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPE_EX: state_d = (funct == FN_JR) ? S_FETCH : S_RTYPE_WB;
            S_ADDI_EX,
            S_ANDI_EX,
            S_ORI_EX:   state_d = S_IMM_WB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
    end

    // Moore decode, except FETCH handshake gating and the jr PC write.
    always_comb begin
        alu_op     = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_zero   = 1'b0;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD:    iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
                pc_write  = (funct == FN_JR);
            end
            S_RTYPE_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BEQ_EX: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_ADDI_EX, S_ANDI_EX, S_ORI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_zero  = (state_q != S_ADDI_EX);
                alu_op    = (state_q == S_ANDI_EX) ? 3'b011 :
                            (state_q == S_ORI_EX)  ? 3'b100 : 3'b000;
            end
            S_IMM_WB:   reg_write = 1'b1;
            S_J_EX: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
`default_nettype wire
